// File: rtl/shift_sequencer.sv
// Multicycle shifter for the ALU shift path: SLL or SRA of a 32-bit operand,
// walked down in shift-by-4 steps, then shift-by-1 steps, with a one-cycle ready pulse.
module shift_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_shift,
    input  logic        ctrl_op,
    input  logic [4:0]  ctrl_shiftamt,
    input  logic [31:0] data_operand,
    output logic [31:0] data_result,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic OP_SRA = 1'b1;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  rem_q, rem_d;
    logic        op_q, op_d;
    logic [31:0] result_q, result_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;

    function automatic logic [31:0] step4(input logic [31:0] a, input logic op);
        logic [31:0] r;
        if (op == OP_SRA) begin
            r = {{4{a[31]}}, a[31:4]};
        end else begin
            r = {a[27:0], 4'b0000};
        end
        return r;
    endfunction

    function automatic logic [31:0] step1(input logic [31:0] a, input logic op);
        logic [31:0] r;
        if (op == OP_SRA) begin
            r = {a[31], a[31:1]};
        end else begin
            r = {a[30:0], 1'b0};
        end
        return r;
    endfunction

    // Next-state logic: accept in IDLE, step and detect completion in SHIFT.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_d     = op_q;
        result_d = result_q;
        rdy_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_shift) begin
                    acc_d   = data_operand;
                    rem_d   = ctrl_shiftamt;
                    op_d    = ctrl_op;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (rem_q >= 5'd4) begin
                    acc_d = step4(acc_q, op_q);
                    rem_d = rem_q - 5'd4;
                end else if (rem_q >= 5'd1) begin
                    acc_d = step1(acc_q, op_q);
                    rem_d = rem_q - 5'd1;
                end else begin
                    acc_d = acc_q;
                    rem_d = 5'd0;
                end
                // A zero amount completes on the first SHIFT edge with the operand unchanged.
                if (rem_d == 5'd0) begin
                    result_d = acc_d;
                    rdy_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= 32'h0000_0000;
            rem_q    <= 5'd0;
            op_q     <= 1'b0;
            result_q <= 32'h0000_0000;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            result_q <= result_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed table-driven bench for shift_sequencer plus hand-written sequences
// for ignored requests, mid-operation reset and back-to-back issue.
module tb_shift_sequencer;

    logic        clock;
    logic        reset_n;
    logic        ctrl_shift;
    logic        ctrl_op;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_operand;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int n_vec;
    int n_err;

    typedef struct {
        logic        op;
        logic [4:0]  amt;
        logic [31:0] operand;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    shift_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_shift     (ctrl_shift),
        .ctrl_op        (ctrl_op),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_operand   (data_operand),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait for the ready pulse, counting edges since acceptance; busy must stay high meanwhile.
    task automatic wait_ready(input string name, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic busy_bad;
        lat = 0;
        busy_bad = 1'b0;
        while (!data_resultRDY && lat < 40) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            tick();
            lat++;
        end
        check({name, " busy during op"}, {31'd0, busy_bad}, 32'd0);
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, data_result, exp);
        check({name, " busy in ready cycle"}, {31'd0, busy}, 32'd0);
    endtask

    // Issue one request at the current (post-edge) time and scramble inputs after acceptance.
    task automatic issue(input logic op, input logic [4:0] amt, input logic [31:0] opnd);
        ctrl_shift    = 1'b1;
        ctrl_op       = op;
        ctrl_shiftamt = amt;
        data_operand  = opnd;
        tick();
        ctrl_shift    = 1'b0;
        ctrl_op       = ~op;
        ctrl_shiftamt = 5'($urandom_range(31, 0));
        data_operand  = $urandom;
    endtask

    initial begin
        int ready_cnt;
        logic [31:0] held;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{1'b1, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 10};
        vecs[1]  = '{1'b0, 5'd5,  32'h0000_0001, 32'h0000_0020, 2};
        vecs[2]  = '{1'b1, 5'd4,  32'h7FFF_FFF0, 32'h07FF_FFFF, 1};
        vecs[3]  = '{1'b0, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        vecs[4]  = '{1'b1, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        vecs[5]  = '{1'b0, 5'd3,  32'h1234_5678, 32'h91A2_B3C0, 3};
        vecs[6]  = '{1'b1, 5'd1,  32'h8000_0000, 32'hC000_0000, 1};
        vecs[7]  = '{1'b0, 5'd28, 32'h0000_000F, 32'hF000_0000, 7};
        vecs[8]  = '{1'b1, 5'd30, 32'h4000_0000, 32'h0000_0001, 9};
        vecs[9]  = '{1'b0, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 10};
        vecs[10] = '{1'b1, 5'd12, 32'h8765_4321, 32'hFFF8_7654, 3};

        reset_n       = 1'b0;
        ctrl_shift    = 1'b0;
        ctrl_op       = 1'b0;
        ctrl_shiftamt = 5'd0;
        data_operand  = 32'h0000_0000;
        tick();
        tick();
        check("reset data_result", data_result, 32'h0000_0000);
        check("reset ready", {31'd0, data_resultRDY}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(vecs[i].op, vecs[i].amt, vecs[i].operand);
            wait_ready(nm, vecs[i].exp, vecs[i].lat);
            tick();
            check({nm, " ready one cycle"}, {31'd0, data_resultRDY}, 32'd0);
            check({nm, " result held"}, data_result, vecs[i].exp);
        end

        // A request while busy must not disturb the latched operands.
        issue(1'b1, 5'd8, 32'hF000_0000);
        ctrl_shift    = 1'b1;
        ctrl_op       = 1'b0;
        ctrl_shiftamt = 5'd1;
        data_operand  = 32'h1234_5678;
        tick();
        ctrl_shift = 1'b0;
        check("ignored: no early ready", {31'd0, data_resultRDY}, 32'd0);
        tick();
        check("ignored: ready at E0+2", {31'd0, data_resultRDY}, 32'd1);
        check("ignored: result", data_result, 32'hFFF0_0000);
        ready_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (data_resultRDY) ready_cnt++;
        end
        check("ignored: single pulse", ready_cnt, 0);
        check("ignored: idle after", {31'd0, busy}, 32'd0);

        // Reset in the middle of a long operation.
        issue(1'b0, 5'd31, 32'h0000_0001);
        for (int c = 0; c < 4; c++) tick();
        reset_n = 1'b0;
        #1;
        check("midreset data_result", data_result, 32'h0000_0000);
        check("midreset ready", {31'd0, data_resultRDY}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        ready_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (data_resultRDY) ready_cnt++;
        end
        check("midreset no ready pulse", ready_cnt, 0);
        issue(1'b0, 5'd2, 32'h0000_0003);
        wait_ready("after reset SLL 3 by 2", 32'h0000_000C, 2);
        tick();

        // New request raised in the ready cycle of the previous operation.
        issue(1'b1, 5'd3, 32'hFFFF_FF00);
        wait_ready("b2b first", 32'hFFFF_FFE0, 3);
        held = data_result;
        issue(1'b0, 5'd6, 32'h0000_0003);
        check("b2b accepted busy", {31'd0, busy}, 32'd1);
        check("b2b no ready after accept", {31'd0, data_resultRDY}, 32'd0);
        check("b2b result held", data_result, held);
        wait_ready("b2b second", 32'h0000_00C0, 3);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
